mvu_data_transposer: RTL and testbench

MVU_DATA_TRANSPOSER -- requirements
Module: mvu_data_transposer

---
 rtl/mvu_data_transposer.sv | 104 ++++++++++
 tb/tb_mvu_data_transposer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mvu_data_transposer.sv
// Collects a tile of 16-bit elements from PITO (two per word) and writes it to
// MVU data memory as bit-planes, MSB plane first, one plane per cycle.
module mvu_data_transposer #(
    parameter int XPR_LEN = 32,
    parameter int BDBANKW = 64,
    parameter int BDBANKA = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4:0]         prec,
    input  logic [BDBANKA-1:0] baddr,
    input  logic [XPR_LEN-1:0] iword,
    input  logic               iword_valid,
    output logic               busy,
    output logic               wr_en,
    output logic [BDBANKA-1:0] wr_addr,
    output logic [BDBANKW-1:0] wr_word
);

    localparam int NWORDS = BDBANKW / 2;
    localparam int WCW    = $clog2(NWORDS);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

    state_t                    r_state, w_state_nxt;
    logic [4:0]                r_prec;
    logic [4:0]                r_pcnt;
    logic [4:0]                w_k_nxt;
    logic [3:0]                w_plane;
    logic [BDBANKA-1:0]        r_baddr;
    logic [WCW-1:0]            r_wcnt;
    logic [BDBANKW-1:0][15:0]  r_elem;
    logic [BDBANKW-1:0][15:0]  w_elem_nxt;
    logic [BDBANKW-1:0]        w_word_nxt;
    logic                      w_accept;
    logic                      w_start_ok;
    logic                      r_wr_en;
    logic [BDBANKA-1:0]        r_wr_addr;
    logic [BDBANKW-1:0]        r_wr_word;

    always_comb begin
        w_start_ok  = start && (prec != 5'd0) && (prec <= 5'd16);
        w_accept    = (r_state == LOAD) && iword_valid;
        w_state_nxt = r_state;
        w_k_nxt     = '0;
        case (r_state)
            IDLE:  if (w_start_ok) w_state_nxt = LOAD;
            LOAD:  if (w_accept && (r_wcnt == WCW'(NWORDS - 1))) w_state_nxt = WRITE;
            WRITE: begin
                w_k_nxt = r_pcnt + 5'd1;
                if (r_pcnt == r_prec - 5'd1) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_plane = 4'(r_prec - 5'd1 - w_k_nxt);
    end

    // Output plane is taken from the post-edge buffer so the last word lands in the first write.
    for (genvar i = 0; i < BDBANKW; i++) begin : g_lane
        assign w_elem_nxt[i] = (w_accept && (r_wcnt == WCW'(i / 2)))
                               ? iword[16*(i%2) +: 16] : r_elem[i];
        assign w_word_nxt[i] = w_elem_nxt[i][w_plane];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_prec    <= '0;
            r_baddr   <= '0;
            r_wcnt    <= '0;
            r_pcnt    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_word <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= (w_state_nxt == WRITE);
            if (r_state == IDLE && w_start_ok) begin
                r_prec  <= prec;
                r_baddr <= baddr;
                r_wcnt  <= '0;
                r_pcnt  <= '0;
            end
            if (w_accept) r_wcnt <= r_wcnt + 1'b1;
            if (w_state_nxt == WRITE) begin
                r_pcnt    <= w_k_nxt;
                r_wr_addr <= r_baddr + BDBANKA'(w_k_nxt);
                r_wr_word <= w_word_nxt;
            end
        end
    end

    // Element buffer content is meaningless until a full tile is loaded.
    always_ff @(posedge clk) begin
        r_elem <= w_elem_nxt;
    end

    assign busy    = (r_state != IDLE);
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_word = r_wr_word;

endmodule

// File: tb/tb_mvu_data_transposer.sv
// Directed bench for mvu_data_transposer: loads tiles, checks every plane write.
module tb_mvu_data_transposer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  prec;
    logic [14:0] baddr;
    logic [31:0] iword;
    logic        iword_valid;
    logic        busy;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [63:0] wr_word;

    int total = 0;
    int bad   = 0;

    logic [15:0] elem [64];
    logic [63:0] first_word, last_word;
    logic [14:0] first_addr, last_addr;

    mvu_data_transposer #(.XPR_LEN(32), .BDBANKW(64), .BDBANKA(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prec(prec), .baddr(baddr),
        .iword(iword), .iword_valid(iword_valid), .busy(busy), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_word(wr_word)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       elem[i] = 16'(i);
                1:       elem[i] = 16'hFFFF;
                2:       elem[i] = 16'(i * 16'h1357 + 16'h2468);
                default: elem[i] = 16'(16'hF0F0 ^ (i * 7));
            endcase
        end
    endtask

    function automatic logic [63:0] plane(input int p);
        logic [63:0] w;
        for (int i = 0; i < 64; i++) w[i] = elem[i][p];
        return w;
    endfunction

    // stop >= 0 asserts reset once that many writes have been checked.
    task automatic do_xfer(input logic [4:0] p, input logic [14:0] a, input bit gap,
                           input bit junk, input bit overlap, input int stop);
        logic [14:0] ea;
        start = 1'b1; prec = p; baddr = a;
        iword = 32'hDEAD_BEEF; iword_valid = junk;
        step();
        start = 1'b0; iword_valid = 1'b0;
        chk("busy_rise", 64'(busy), 64'd1);
        for (int n = 0; n < 32; n++) begin
            iword = {elem[2*n+1], elem[2*n]};
            iword_valid = 1'b1;
            if (overlap && n == 5) begin
                start = 1'b1; prec = 5'd3; baddr = 15'h0200;
            end
            step();
            start = 1'b0;
            if (n != 31) begin
                chk("no_wr_load", 64'(wr_en), 64'd0);
                if (gap) begin
                    iword_valid = 1'b0; iword = 32'hFFFF_FFFF;
                    step();
                    chk("no_wr_stall", 64'(wr_en), 64'd0);
                    chk("busy_stall", 64'(busy), 64'd1);
                end
            end
        end
        iword_valid = 1'b0;
        for (int k = 0; k < int'(p); k++) begin
            if (k == stop) begin
                rst_n = 1'b0;
                #1;
                chk("rst_wr_en", 64'(wr_en), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_addr", 64'(wr_addr), 64'd0);
                chk("rst_word", wr_word, 64'd0);
                return;
            end
            ea = a + 15'(k);
            chk("wr_en", 64'(wr_en), 64'd1);
            chk("wr_addr", 64'(wr_addr), 64'(ea));
            chk("wr_word", wr_word, plane(int'(p) - 1 - k));
            if (k == 0) begin first_word = wr_word; first_addr = wr_addr; end
            last_word = wr_word; last_addr = wr_addr;
            step();
        end
        chk("wr_en_end", 64'(wr_en), 64'd0);
        chk("busy_fall", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; prec = '0; baddr = '0;
        iword = '0; iword_valid = 1'b0;
        step(); step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_addr", 64'(wr_addr), 64'd0);
        chk("reset_word", wr_word, 64'd0);
        rst_n = 1'b1;

        // Basic 8-bit tile, with a stray valid on the start cycle
        fill(0);
        do_xfer(5'd8, 15'h0100, 1'b0, 1'b1, 1'b0, -1);
        chk("basic_first_word", first_word, 64'd0);
        chk("basic_last_word", last_word, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("basic_first_addr", 64'(first_addr), 64'h0100);
        chk("basic_last_addr", 64'(last_addr), 64'h0107);

        // Illegal precisions are ignored
        start = 1'b1; prec = 5'd0; baddr = 15'h0010;
        step(); start = 1'b0;
        chk("prec0_busy", 64'(busy), 64'd0);
        step();
        chk("prec0_busy2", 64'(busy), 64'd0);
        start = 1'b1; prec = 5'd17;
        step(); start = 1'b0;
        chk("prec17_busy", 64'(busy), 64'd0);
        chk("prec17_wr_en", 64'(wr_en), 64'd0);

        // Truncation to one plane, top address
        fill(1);
        do_xfer(5'd1, 15'h7FFF, 1'b0, 1'b0, 1'b0, -1);
        chk("p1_word", first_word, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("p1_addr", 64'(first_addr), 64'h7FFF);

        // Address wrap
        do_xfer(5'd2, 15'h7FFF, 1'b0, 1'b0, 1'b0, -1);
        chk("wrap_first_addr", 64'(first_addr), 64'h7FFF);
        chk("wrap_last_addr", 64'(last_addr), 64'h0000);

        // Stalled input stream
        fill(2);
        do_xfer(5'd4, 15'h0020, 1'b1, 1'b0, 1'b0, -1);

        // Overlapping start during LOAD must not disturb the transfer
        do_xfer(5'd6, 15'h0040, 1'b0, 1'b0, 1'b1, -1);
        chk("overlap_first_addr", 64'(first_addr), 64'h0040);
        chk("overlap_last_addr", 64'(last_addr), 64'h0045);

        // Full 16-bit precision
        fill(3);
        do_xfer(5'd16, 15'h1230, 1'b0, 1'b0, 1'b0, -1);

        // Reset after the 3rd of 5 writes, then a fresh transfer
        fill(2);
        do_xfer(5'd5, 15'h0300, 1'b0, 1'b0, 1'b0, 3);
        step();
        chk("rst_hold_wr_en", 64'(wr_en), 64'd0);
        rst_n = 1'b1;
        fill(3);
        do_xfer(5'd5, 15'h0400, 1'b0, 1'b0, 1'b0, -1);
        chk("post_rst_last_addr", 64'(last_addr), 64'h0404);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
